i8254_rw_ctrl: RTL and testbench
================================

# i8254_rw_ctrl

Per-counter access controller for the 8254 timer: decodes control words, sequences LSB/MSB initial-count writes into the counter datapath (e.g. the mode-1 counter), and sequences count-latch and read-back reads onto the data bus. One instance sits between the bus interface and each of the three counters. It owns the mode/BCD configuration and the null-count flag that the counter consumes.

## Interface
Parameters:
- COUNTER_ID, 0, counter this instance serves (0..2); selects port address A == COUNTER_ID and the SC field it responds to.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- cs  in  1  chip select, active high; wr/rd ignored while low
- wr  in  1  one-cycle write strobe
- rd  in  1  one-cycle read strobe
- a  in  2  register address (3 = control word)
- din  in  8  write data
- cnt_in  in  16  live count from counter datapath
- out_in  in  1  counter OUT pin level, for status byte
- load_ack  in  1  counter has taken count_load into its count register
- dout  out  8  read data
- dout_valid  out  1  one-cycle pulse, dout valid
- count_load  out  16  assembled initial count
- load_strobe  out  1  one-cycle pulse, count_load complete
- mode  out  3  programmed mode (0..5)
- bcd  out  1  programmed BCD flag
- cfg_strobe  out  1  one-cycle pulse on accepted control word for this counter

## Operation
- Accepted access: cs=1 and wr or rd. wr and rd together: wr executes, rd dropped.
- Control word (a=3, din[7:6]==COUNTER_ID): din[5:4]=00 is a count latch command, otherwise program: rw<=din[5:4], mode<=din[3:1] with 6→2 and 7→3, bcd<=din[0], null_count<=1, write and read byte pointers cleared, latches cleared, pending LSB discarded, cfg_strobe pulses.
- Count write (a=COUNTER_ID): rw=01 → count_load={8'h00,din}, load; rw=10 → {din,8'h00}, load; rw=11 → first byte stored as LSB, second forms {din,lsb} and loads, pointer toggles; rw=00 (unprogrammed) → ignored.
- load_strobe sets null_count; wait — null_count remains 1 until load_ack, then clears. Count value 0 passes unchanged.
- Latch command: captures cnt_in into latch if no count latch pending; ignored while one is pending. Latch releases once fully read per rw (1 or 2 bytes).
- Read (a=COUNTER_ID): priority status latch, then count latch, then live cnt_in; byte chosen by rw/read pointer (11 alternates LSB, MSB). rw=00 returns 8'h00.
- States: IDLE, WR_MSB_PEND, and independent read pointer RD_LSB/RD_MSB.

## Timing
- Reset values: dout=0, dout_valid=0, count_load=0, load_strobe=0, mode=0, bcd=0, cfg_strobe=0, rw=00, null_count=0, pointers cleared, latches empty.
- dout/dout_valid: one cycle after rd edge. load_strobe/cfg_strobe: one cycle after the final wr edge; count_load stable from load_strobe until next load.
- Latch captures cnt_in as sampled on the command edge.
- Reset mid-sequence discards all pending bytes and latches; cs low holds state.

## Configuration
- I8254_READBACK_EN defined: control word SC=11 is a read-back command; din[5]=0 latches count, din[4]=0 latches status {out_in,null_count,rw,mode,bcd}, din[1+COUNTER_ID] selects this counter; existing latches not overwritten; status byte read first.
- Undefined: SC=11 control words ignored; no status latch logic.

## Test plan
- Reset, control word 8'h32 (COUNTER_ID=0, rw=11, mode 1), write 8'h34 then 8'h12 → one load_strobe, count_load=16'h1234, mode=1, cfg_strobe once.
- Control word 8'h1E (rw=01, mode 7) → mode=3; write 8'hAA → count_load=16'h00AA.
- rw=11, cnt_in=16'hBEEF, latch 8'h00, change cnt_in to 16'h0001, two reads → 8'hEF, 8'hBE; third read returns live 8'h01.
- rw=11, LSB written, then new control word, then 8'h05, 8'h00 → single load, count_load=16'h0005.
- wr and rd same cycle → write executes, no dout_valid; cs=0 strobes → no outputs change.
- With I8254_READBACK_EN, read-back 8'hC2 with out_in=1, rw=11, mode 1, null_count=1 → first read 8'hF2, next reads count LSB, MSB.

Source files
------------

// File: rtl/i8254_rw_ctrl.sv
// i8254_rw_ctrl: per-counter access controller for an 8254-style timer.
// It decodes control words and assembles LSB/MSB initial-count writes into
// count_load. It also sequences count-latch, status-latch and live-count
// reads onto dout. It owns the rw/mode/bcd configuration and the null-count
// flag.
// Optional feature macro: I8254_READBACK_EN
//   When this macro is defined, SC=11 control words are read-back commands
//   that can latch the count and/or the status byte of this counter.
//   When it is undefined, SC=11 control words are ignored and no status
//   latch exists.
module i8254_rw_ctrl #(
  parameter int COUNTER_ID = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [1:0]  a,
  input  logic [7:0]  din,
  input  logic [15:0] cnt_in,
  input  logic        out_in,
  input  logic        load_ack,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic [15:0] count_load,
  output logic        load_strobe,
  output logic [2:0]  mode,
  output logic        bcd,
  output logic        cfg_strobe
);

  localparam logic [1:0] CID = 2'(COUNTER_ID);

  typedef enum logic {IDLE, WR_MSB_PEND} wr_state_t;
  typedef enum logic {RD_LSB, RD_MSB}    rd_state_t;

  wr_state_t   wr_state_reg, wr_state_next;
  rd_state_t   rd_state_reg, rd_state_next;
  logic [1:0]  rw_reg, rw_next;
  logic [2:0]  mode_reg, mode_next;
  logic        bcd_reg, bcd_next;
  logic        null_count_reg, null_count_next;
  logic [7:0]  lsb_reg, lsb_next;
  logic [15:0] cnt_latch_reg, cnt_latch_next;
  logic        cnt_latched_reg, cnt_latched_next;
  logic [15:0] count_load_reg, count_load_next;
  logic        load_strobe_reg, load_strobe_next;
  logic        cfg_strobe_reg, cfg_strobe_next;
  logic [7:0]  dout_reg, dout_next;
  logic        dout_valid_reg, dout_valid_next;

  logic        do_wr;
  logic        do_rd;
  logic [15:0] rd_src;
  logic        take_status;

  // A write wins over a simultaneous read; the read is simply dropped.
  assign do_wr  = cs & wr;
  assign do_rd  = cs & rd & ~wr;
  // Count reads come from the latch while one is held, else the live count.
  assign rd_src = cnt_latched_reg ? cnt_latch_reg : cnt_in;

`ifdef I8254_READBACK_EN
  localparam int RB_BIT = 1 + COUNTER_ID;
  logic [7:0] status_latch_reg, status_latch_next;
  logic       status_latched_reg, status_latched_next;
  logic [7:0] status_byte;

  assign status_byte = {out_in, null_count_reg, rw_reg, mode_reg, bcd_reg};
  assign take_status = status_latched_reg;

  // Status latch register, only present with read-back support.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_latch_reg   <= 8'h00;
      status_latched_reg <= 1'b0;
    end else begin
      status_latch_reg   <= status_latch_next;
      status_latched_reg <= status_latched_next;
    end
  end
`else
  logic unused_out_in;
  assign unused_out_in = out_in;
  assign take_status   = 1'b0;
`endif

  // State and output registers; reset discards any pending byte or latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_state_reg    <= IDLE;
      rd_state_reg    <= RD_LSB;
      rw_reg          <= 2'b00;
      mode_reg        <= 3'd0;
      bcd_reg         <= 1'b0;
      null_count_reg  <= 1'b0;
      lsb_reg         <= 8'h00;
      cnt_latch_reg   <= 16'h0000;
      cnt_latched_reg <= 1'b0;
      count_load_reg  <= 16'h0000;
      load_strobe_reg <= 1'b0;
      cfg_strobe_reg  <= 1'b0;
      dout_reg        <= 8'h00;
      dout_valid_reg  <= 1'b0;
    end else begin
      wr_state_reg    <= wr_state_next;
      rd_state_reg    <= rd_state_next;
      rw_reg          <= rw_next;
      mode_reg        <= mode_next;
      bcd_reg         <= bcd_next;
      null_count_reg  <= null_count_next;
      lsb_reg         <= lsb_next;
      cnt_latch_reg   <= cnt_latch_next;
      cnt_latched_reg <= cnt_latched_next;
      count_load_reg  <= count_load_next;
      load_strobe_reg <= load_strobe_next;
      cfg_strobe_reg  <= cfg_strobe_next;
      dout_reg        <= dout_next;
      dout_valid_reg  <= dout_valid_next;
    end
  end

  // Next-state logic: control word decode, count write sequencing, reads.
  always_comb begin
    wr_state_next    = wr_state_reg;
    rd_state_next    = rd_state_reg;
    rw_next          = rw_reg;
    mode_next        = mode_reg;
    bcd_next         = bcd_reg;
    null_count_next  = null_count_reg;
    lsb_next         = lsb_reg;
    cnt_latch_next   = cnt_latch_reg;
    cnt_latched_next = cnt_latched_reg;
    count_load_next  = count_load_reg;
    load_strobe_next = 1'b0;
    cfg_strobe_next  = 1'b0;
    dout_next        = dout_reg;
    dout_valid_next  = 1'b0;
`ifdef I8254_READBACK_EN
    status_latch_next   = status_latch_reg;
    status_latched_next = status_latched_reg;
`endif

    // The counter acknowledging its load clears null count; a new load or
    // a new control word in the same cycle sets it again below.
    if (load_ack) begin
      null_count_next = 1'b0;
    end

    if (do_wr) begin
      if (a == 2'd3) begin
        if (din[7:6] == CID) begin
          if (din[5:4] == 2'b00) begin
            // Count latch command: a latch still being read is kept.
            if (!cnt_latched_reg) begin
              cnt_latch_next   = cnt_in;
              cnt_latched_next = 1'b1;
            end
          end else begin
            // Program: modes 6 and 7 alias to 2 and 3.
            rw_next          = din[5:4];
            mode_next        = (din[3] & din[2]) ? {1'b0, din[2:1]} : din[3:1];
            bcd_next         = din[0];
            null_count_next  = 1'b1;
            wr_state_next    = IDLE;
            rd_state_next    = RD_LSB;
            cnt_latched_next = 1'b0;
            cfg_strobe_next  = 1'b1;
`ifdef I8254_READBACK_EN
            status_latched_next = 1'b0;
`endif
          end
        end
`ifdef I8254_READBACK_EN
        else if (din[7:6] == 2'b11 && din[RB_BIT]) begin
          // Read-back: latch count and/or status; held latches are kept.
          if (!din[5] && !cnt_latched_reg) begin
            cnt_latch_next   = cnt_in;
            cnt_latched_next = 1'b1;
          end
          if (!din[4] && !status_latched_reg) begin
            status_latch_next   = status_byte;
            status_latched_next = 1'b1;
          end
        end
`endif
      end else if (a == CID) begin
        unique case (rw_reg)
          2'b01: begin
            count_load_next  = {8'h00, din};
            load_strobe_next = 1'b1;
            null_count_next  = 1'b1;
          end
          2'b10: begin
            count_load_next  = {din, 8'h00};
            load_strobe_next = 1'b1;
            null_count_next  = 1'b1;
          end
          2'b11: begin
            if (wr_state_reg == IDLE) begin
              lsb_next      = din;
              wr_state_next = WR_MSB_PEND;
            end else begin
              count_load_next  = {din, lsb_reg};
              load_strobe_next = 1'b1;
              null_count_next  = 1'b1;
              wr_state_next    = IDLE;
            end
          end
          default: begin
            // Unprogrammed counter: the write is ignored.
          end
        endcase
      end
    end else if (do_rd && a == CID) begin
      dout_valid_next = 1'b1;
      if (take_status) begin
        // A pending status byte is always returned first.
`ifdef I8254_READBACK_EN
        dout_next           = status_latch_reg;
        status_latched_next = 1'b0;
`endif
      end else begin
        unique case (rw_reg)
          2'b01: begin
            dout_next        = rd_src[7:0];
            cnt_latched_next = 1'b0;
          end
          2'b10: begin
            dout_next        = rd_src[15:8];
            cnt_latched_next = 1'b0;
          end
          2'b11: begin
            if (rd_state_reg == RD_LSB) begin
              dout_next     = rd_src[7:0];
              rd_state_next = RD_MSB;
            end else begin
              dout_next        = rd_src[15:8];
              rd_state_next    = RD_LSB;
              cnt_latched_next = 1'b0;
            end
          end
          default: begin
            dout_next = 8'h00;
          end
        endcase
      end
    end
  end

  assign dout        = dout_reg;
  assign dout_valid  = dout_valid_reg;
  assign count_load  = count_load_reg;
  assign load_strobe = load_strobe_reg;
  assign mode        = mode_reg;
  assign bcd         = bcd_reg;
  assign cfg_strobe  = cfg_strobe_reg;

endmodule

// File: tb/tb_i8254_rw_ctrl.sv
// Testbench for i8254_rw_ctrl (COUNTER_ID = 0).
// The stimulus driver updates a behavioural model of the counter's access
// rules and queues each expected response. A monitor pops and compares the
// queued response whenever the DUT pulses dout_valid, load_strobe or
// cfg_strobe. Read-back checks are compiled in when I8254_READBACK_EN is set.
module tb_i8254_rw_ctrl;

  localparam int         CID  = 0;
  localparam logic [1:0] CID2 = 2'd0;

  logic        clk = 1'b0;
  logic        rst_n, cs, wr, rd, out_in, load_ack;
  logic [1:0]  a;
  logic [7:0]  din;
  logic [15:0] cnt_in;
  logic [7:0]  dout;
  logic        dout_valid, load_strobe, bcd, cfg_strobe;
  logic [15:0] count_load;
  logic [2:0]  mode;

  always #5 clk = ~clk;

  i8254_rw_ctrl #(.COUNTER_ID(CID)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .a(a), .din(din),
    .cnt_in(cnt_in), .out_in(out_in), .load_ack(load_ack),
    .dout(dout), .dout_valid(dout_valid), .count_load(count_load),
    .load_strobe(load_strobe), .mode(mode), .bcd(bcd), .cfg_strobe(cfg_strobe)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] exp_load_q[$];
  logic [3:0]  exp_cfg_q[$];
  logic [7:0]  exp_rd_q[$];

  // Reference model state
  logic [1:0]  m_rw;
  logic [2:0]  m_mode;
  logic        m_bcd, m_null;
  logic        m_have_lsb;
  logic [7:0]  m_lsb;
  logic        m_next_msb;
  logic        m_cl_valid;
  logic [15:0] m_cl_val;
  logic        m_st_valid;
  logic [7:0]  m_st_val;
  logic [15:0] m_count_load;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_rw = 2'b00; m_mode = 3'd0; m_bcd = 1'b0; m_null = 1'b0;
    m_have_lsb = 1'b0; m_lsb = 8'h00; m_next_msb = 1'b0;
    m_cl_valid = 1'b0; m_cl_val = 16'h0; m_st_valid = 1'b0; m_st_val = 8'h0;
    m_count_load = 16'h0;
    exp_load_q.delete(); exp_cfg_q.delete(); exp_rd_q.delete();
  endtask

  task automatic model_load(input logic [15:0] v);
    m_count_load = v;
    exp_load_q.push_back(v);
  endtask

  // Apply one bus cycle to the model using the pre-edge state.
  task automatic model_step(input logic c, input logic w_in, input logic r_in,
                            input logic [1:0] aa, input logic [7:0] d, input logic ack);
    logic        w, r, set_null;
    logic [2:0]  md;
    logic [15:0] v;
    logic [7:0]  b;
    w = c & w_in;
    r = c & r_in & ~w_in;
    set_null = 1'b0;
    if (w && aa == 2'd3 && d[7:6] == CID2) begin
      if (d[5:4] == 2'b00) begin
        if (!m_cl_valid) begin m_cl_valid = 1'b1; m_cl_val = cnt_in; end
      end else begin
        md = d[3:1];
        if (md > 3'd5) md = md - 3'd4;
        m_rw = d[5:4]; m_mode = md; m_bcd = d[0]; set_null = 1'b1;
        m_have_lsb = 1'b0; m_next_msb = 1'b0; m_cl_valid = 1'b0; m_st_valid = 1'b0;
        exp_cfg_q.push_back({m_mode, m_bcd});
      end
    end
`ifdef I8254_READBACK_EN
    else if (w && aa == 2'd3 && d[7:6] == 2'b11 && d[1 + CID]) begin
      if (!d[5] && !m_cl_valid) begin m_cl_valid = 1'b1; m_cl_val = cnt_in; end
      if (!d[4] && !m_st_valid) begin
        m_st_valid = 1'b1;
        m_st_val = {out_in, m_null, m_rw, m_mode, m_bcd};
      end
    end
`endif
    else if (w && aa == CID2) begin
      if (m_rw == 2'b01) begin model_load({8'h00, d}); set_null = 1'b1; end
      else if (m_rw == 2'b10) begin model_load({d, 8'h00}); set_null = 1'b1; end
      else if (m_rw == 2'b11) begin
        if (!m_have_lsb) begin m_have_lsb = 1'b1; m_lsb = d; end
        else begin model_load({d, m_lsb}); set_null = 1'b1; m_have_lsb = 1'b0; end
      end
    end else if (r && aa == CID2) begin
      if (m_st_valid) begin
        b = m_st_val; m_st_valid = 1'b0;
      end else begin
        v = m_cl_valid ? m_cl_val : cnt_in;
        if (m_rw == 2'b00) b = 8'h00;
        else if (m_rw == 2'b01) begin b = v[7:0]; m_cl_valid = 1'b0; end
        else if (m_rw == 2'b10) begin b = v[15:8]; m_cl_valid = 1'b0; end
        else begin
          b = m_next_msb ? v[15:8] : v[7:0];
          if (m_next_msb) m_cl_valid = 1'b0;
          m_next_msb = ~m_next_msb;
        end
      end
      exp_rd_q.push_back(b);
    end
    if (ack) m_null = 1'b0;
    if (set_null) m_null = 1'b1;
  endtask

  // One bus cycle: drive inputs at negedge, update model, return just after posedge.
  task automatic cyc(input logic c, input logic w, input logic r, input logic [1:0] aa,
                     input logic [7:0] d, input logic ack);
    @(negedge clk);
    cs = c; wr = w; rd = r; a = aa; din = d; load_ack = ack;
    model_step(c, w, r, aa, d, ack);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0; a = 2'd0; din = 8'h00; load_ack = 1'b0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_cfg_outputs(input string name);
    check({name, "_mode"}, 16'(mode), 16'(m_mode));
    check({name, "_bcd"}, 16'(bcd), 16'(m_bcd));
    check({name, "_count_load"}, count_load, m_count_load);
  endtask

  // Monitor: compare each DUT output pulse against the oldest queued expectation.
  always @(negedge clk) begin
    if (load_strobe) begin
      if (exp_load_q.size() == 0) check("load_unexpected", count_load, 16'hxxxx);
      else check("load", count_load, exp_load_q.pop_front());
    end
    if (cfg_strobe) begin
      if (exp_cfg_q.size() == 0) check("cfg_unexpected", 16'({mode, bcd}), 16'hxxxx);
      else check("cfg", 16'({mode, bcd}), 16'(exp_cfg_q.pop_front()));
    end
    if (dout_valid) begin
      if (exp_rd_q.size() == 0) check("read_unexpected", 16'(dout), 16'hxxxx);
      else check("read", 16'(dout), 16'(exp_rd_q.pop_front()));
    end
  end

  initial begin
    cnt_in = 16'h0000; out_in = 1'b0;
    do_reset();

    // Reset state
    check("rst_dout", 16'(dout), 16'h0);
    check("rst_dout_valid", 16'(dout_valid), 16'h0);
    check("rst_count_load", count_load, 16'h0);
    check("rst_load_strobe", 16'(load_strobe), 16'h0);
    check("rst_mode", 16'(mode), 16'h0);
    check("rst_bcd", 16'(bcd), 16'h0);
    check("rst_cfg_strobe", 16'(cfg_strobe), 16'h0);

    // rw=11 mode 1, LSB then MSB
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    check("tp1_cfg_strobe", 16'(cfg_strobe), 16'h1);
    cyc(1, 1, 0, 2'd0, 8'h34, 0);
    check("tp1_no_load_after_lsb", 16'(load_strobe), 16'h0);
    cyc(1, 1, 0, 2'd0, 8'h12, 0);
    check("tp1_load_strobe", 16'(load_strobe), 16'h1);
    check("tp1_count_load", count_load, 16'h1234);
    check("tp1_mode", 16'(mode), 16'h1);
    idle(2);

    // Mode 7 aliases to 3, rw=01
    cyc(1, 1, 0, 2'd3, 8'h1E, 0);
    cyc(1, 1, 0, 2'd0, 8'hAA, 0);
    check("tp2_mode", 16'(mode), 16'h3);
    check("tp2_count_load", count_load, 16'h00AA);
    idle(1);

    // Count latch, then read latched LSB/MSB, then live LSB
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    cnt_in = 16'hBEEF;
    cyc(1, 1, 0, 2'd3, 8'h00, 0);
    cnt_in = 16'h0001;
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp3_rd0", 16'(dout), 16'h00EF);
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp3_rd1", 16'(dout), 16'h00BE);
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp3_rd2_live", 16'(dout), 16'h0001);
    idle(1);

    // A new control word discards a pending LSB
    cyc(1, 1, 0, 2'd0, 8'h77, 0);
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    cyc(1, 1, 0, 2'd0, 8'h05, 0);
    cyc(1, 1, 0, 2'd0, 8'h00, 0);
    check("tp4_count_load", count_load, 16'h0005);
    idle(1);

    // wr and rd together: write executes, no read data
    cyc(1, 1, 0, 2'd3, 8'h1E, 0);
    cyc(1, 1, 1, 2'd0, 8'h55, 0);
    check("tp5_load_strobe", 16'(load_strobe), 16'h1);
    check("tp5_count_load", count_load, 16'h0055);
    idle(1);
    check("tp5_no_dout_valid", 16'(dout_valid), 16'h0);
    // cs low: nothing happens
    cyc(0, 1, 0, 2'd3, 8'h36, 0);
    cyc(0, 1, 0, 2'd0, 8'h99, 0);
    cyc(0, 0, 1, 2'd0, 8'h00, 0);
    check("tp5_cs_low_dv", 16'(dout_valid), 16'h0);
    check_cfg_outputs("tp5_cs_low");

    // Reset mid-sequence discards the pending LSB
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    cyc(1, 1, 0, 2'd0, 8'h11, 0);
    do_reset();
    check("rst2_mode", 16'(mode), 16'h0);
    cyc(1, 1, 0, 2'd0, 8'h44, 0);
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    cyc(1, 1, 0, 2'd0, 8'h22, 0);
    cyc(1, 1, 0, 2'd0, 8'h33, 0);
    check("rst2_count_load", count_load, 16'h3322);
    idle(1);

`ifdef I8254_READBACK_EN
    // Read-back of count and status
    cyc(1, 1, 0, 2'd3, 8'h32, 0);
    out_in = 1'b1;
    cnt_in = 16'hABCD;
    cyc(1, 1, 0, 2'd3, 8'hC2, 0);
    cnt_in = 16'h0000;
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp6_status", 16'(dout), 16'h00F2);
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp6_lsb", 16'(dout), 16'h00CD);
    cyc(1, 0, 1, 2'd0, 8'h00, 0);
    check("tp6_msb", 16'(dout), 16'h00AB);
    idle(1);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      logic [7:0] d;
      logic       ack;
      int         op;
      cnt_in = 16'($urandom);
      out_in = 1'($urandom);
      d      = 8'($urandom);
      ack    = ($urandom_range(0, 3) == 0);
      op     = $urandom_range(0, 9);
      case (op)
        0: cyc(1, 1, 0, 2'd3, {CID2, d[5:0]}, ack);
        1: cyc(1, 1, 0, 2'd3, d, ack);
        2, 3, 4: cyc(1, 1, 0, CID2, d, ack);
        5, 6, 7: cyc(1, 0, 1, CID2, d, ack);
        8: cyc(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), d, ack);
        default: cyc(0, 0, 0, 2'd0, d, ack);
      endcase
    end
    idle(3);

    check("final_load_q_empty", 16'(exp_load_q.size()), 16'h0);
    check("final_cfg_q_empty", 16'(exp_cfg_q.size()), 16'h0);
    check("final_rd_q_empty", 16'(exp_rd_q.size()), 16'h0);
    check_cfg_outputs("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
